// File: rtl/controller.sv
// Purpose: sequencer for a 4-register bus datapath, decodes IR into T1..T3 strobes.
// Latency: Done 1 cycle after accept for ld/cp/illegal, 2 for inv/flp, 3 otherwise.
// Backpressure: Exec is only accepted in IDLE; it is ignored while Busy is high.
module controller (
    input  logic       CLKb,
    input  logic       Rst,
    input  logic [9:0] INST,
    input  logic       Exec,
    output logic [9:0] IMM,
    output logic       ExtImm,
    output logic       ENW,
    output logic [3:0] Rin,
    output logic [3:0] Rout,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic [3:0] FN,
    output logic       Busy,
    output logic       Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] ir_q, ir_d;

    logic [1:0] x_sel, y_sel;
    logic [3:0] op;
    logic [3:0] x_oh, y_oh;
    logic       is_imm, is_illegal, is_ld, is_cp, is_unary;

    // Instruction field decode and class flags from the latched IR.
    always_comb begin
        x_sel      = ir_q[7:6];
        y_sel      = ir_q[5:4];
        op         = ir_q[3:0];
        x_oh       = 4'b0001 << x_sel;
        y_oh       = 4'b0001 << y_sel;
        is_imm     = ir_q[9];
        is_illegal = (ir_q[9:8] == 2'b01) || ((ir_q[9:8] == 2'b00) && (op >= 4'b1100));
        is_ld      = (ir_q[9:8] == 2'b00) && (op == 4'b0000);
        is_cp      = (ir_q[9:8] == 2'b00) && (op == 4'b0001);
        is_unary   = (ir_q[9:8] == 2'b00) && ((op == 4'b0100) || (op == 4'b0101));
    end

    // Next-state logic: accept Exec only in IDLE, return to IDLE after the Done step.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            IDLE: begin
                if (Exec) begin
                    state_d = T1;
                    ir_d    = INST;
                end
            end
            T1: begin
                if (is_illegal || is_ld || is_cp) state_d = IDLE;
                else                              state_d = T2;
            end
            T2: begin
                if (is_unary) state_d = IDLE;
                else          state_d = T3;
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs: strobes are a function of the timestep and IR only.
    always_comb begin
        IMM    = {4'b0000, ir_q[5:0]};
        ExtImm = 1'b0;
        ENW    = 1'b0;
        Rin    = 4'b0000;
        Rout   = 4'b0000;
        Ain    = 1'b0;
        Gin    = 1'b0;
        Gout   = 1'b0;
        FN     = 4'b0000;
        Busy   = (state_q != IDLE);
        Done   = 1'b0;
        case (state_q)
            T1: begin
                if (is_illegal) begin
                    Done = 1'b1;
                end else if (is_ld) begin
                    ENW  = 1'b1;
                    Rin  = x_oh;
                    Done = 1'b1;
                end else if (is_cp) begin
                    Rout = y_oh;
                    Rin  = x_oh;
                    Done = 1'b1;
                end else if (is_unary) begin
                    Rout = y_oh;
                    Gin  = 1'b1;
                    FN   = op;
                end else begin
                    // binary ALU ops and addi/subi both stage X into A first
                    Rout = x_oh;
                    Ain  = 1'b1;
                end
            end
            T2: begin
                if (is_unary) begin
                    Gout = 1'b1;
                    Rin  = x_oh;
                    Done = 1'b1;
                end else if (is_imm) begin
                    ExtImm = 1'b1;
                    Gin    = 1'b1;
                    FN     = ir_q[8] ? 4'b0011 : 4'b0010;
                end else begin
                    Rout = y_oh;
                    Gin  = 1'b1;
                    FN   = op;
                end
            end
            T3: begin
                Gout = 1'b1;
                Rin  = x_oh;
                Done = 1'b1;
            end
            default: ;
        endcase
    end

    // State and IR registers on the falling edge; reset aborts any in-flight instruction.
    always_ff @(negedge CLKb) begin
        if (Rst) begin
            state_q <= IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_controller.sv
module tb_controller;

    logic       CLKb = 1'b1;
    logic       Rst  = 1'b1;
    logic [9:0] INST = '0;
    logic       Exec = 1'b0;
    logic [9:0] IMM;
    logic       ExtImm, ENW, Ain, Gin, Gout, Busy, Done;
    logic [3:0] Rin, Rout, FN;

    controller dut (
        .CLKb(CLKb), .Rst(Rst), .INST(INST), .Exec(Exec),
        .IMM(IMM), .ExtImm(ExtImm), .ENW(ENW), .Rin(Rin), .Rout(Rout),
        .Ain(Ain), .Gin(Gin), .Gout(Gout), .FN(FN), .Busy(Busy), .Done(Done)
    );

    always #5 CLKb = ~CLKb;

    typedef struct packed {
        logic [9:0] imm;
        logic       extimm;
        logic       enw;
        logic [3:0] rin;
        logic [3:0] rout;
        logic       ain;
        logic       gin;
        logic       gout;
        logic [3:0] fn;
        logic       busy;
        logic       done;
    } outv_t;

    typedef struct {
        logic [9:0] inst;
        int         lat;
        logic [3:0] rin_done;
    } vec_t;

    outv_t      exp_q[$];
    outv_t      cur;
    logic [9:0] ir_m;
    int         checks = 0;
    int         errors = 0;

    function automatic logic [3:0] oh(input logic [1:0] s);
        oh = 4'b0001 << s;
    endfunction

    function automatic outv_t idle_vec(input logic [9:0] ir);
        outv_t v;
        v     = '0;
        v.imm = {4'b0000, ir[5:0]};
        return v;
    endfunction

    // Reference model: push the expected T1..Tn output vectors for an instruction.
    function automatic void push_seq(input logic [9:0] i);
        outv_t b, t1, t2, t3;
        int n;
        b      = '0;
        b.imm  = {4'b0000, i[5:0]};
        b.busy = 1'b1;
        t1 = b; t2 = b; t3 = b;
        if (i[9:8] == 2'b01 || (i[9:8] == 2'b00 && i[3:0] >= 4'd12)) begin
            t1.done = 1'b1; n = 1;
        end else if (i[9]) begin
            t1.rout = oh(i[7:6]); t1.ain = 1'b1;
            t2.extimm = 1'b1; t2.gin = 1'b1; t2.fn = i[8] ? 4'd3 : 4'd2;
            t3.gout = 1'b1; t3.rin = oh(i[7:6]); t3.done = 1'b1; n = 3;
        end else if (i[3:0] == 4'd0) begin
            t1.enw = 1'b1; t1.rin = oh(i[7:6]); t1.done = 1'b1; n = 1;
        end else if (i[3:0] == 4'd1) begin
            t1.rout = oh(i[5:4]); t1.rin = oh(i[7:6]); t1.done = 1'b1; n = 1;
        end else if (i[3:0] == 4'd4 || i[3:0] == 4'd5) begin
            t1.rout = oh(i[5:4]); t1.gin = 1'b1; t1.fn = i[3:0];
            t2.gout = 1'b1; t2.rin = oh(i[7:6]); t2.done = 1'b1; n = 2;
        end else begin
            t1.rout = oh(i[7:6]); t1.ain = 1'b1;
            t2.rout = oh(i[5:4]); t2.gin = 1'b1; t2.fn = i[3:0];
            t3.gout = 1'b1; t3.rin = oh(i[7:6]); t3.done = 1'b1; n = 3;
        end
        exp_q.push_back(t1);
        if (n > 1) exp_q.push_back(t2);
        if (n > 2) exp_q.push_back(t3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, update the model at the active edge, compare at the next rising edge.
    task automatic tick(input logic r, input logic e, input logic [9:0] i);
        outv_t act;
        Rst = r; Exec = e; INST = i;
        @(negedge CLKb);
        if (r) begin
            exp_q.delete();
            ir_m = '0;
            cur  = idle_vec(ir_m);
        end else if (!cur.busy && e) begin
            ir_m = i;
            push_seq(i);
            cur = exp_q.pop_front();
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else begin
            cur = idle_vec(ir_m);
        end
        @(posedge CLKb);
        act = '{IMM, ExtImm, ENW, Rin, Rout, Ain, Gin, Gout, FN, Busy, Done};
        chk("scoreboard", 32'(act), 32'(cur));
    endtask

    vec_t tbl [13];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{10'b00_10_00_0000, 1, 4'b0100};  // ld R2
        tbl[1]  = '{10'b00_01_10_0001, 1, 4'b0010};  // cp R1,R2
        tbl[2]  = '{10'b00_00_11_0100, 2, 4'b0001};  // inv R0,R3
        tbl[3]  = '{10'b00_11_01_0101, 2, 4'b1000};  // flp R3,R1
        tbl[4]  = '{10'b00_01_11_0010, 3, 4'b0010};  // add R1,R3
        tbl[5]  = '{10'b00_10_00_0011, 3, 4'b0100};  // sub R2,R0
        tbl[6]  = '{10'b00_00_01_0110, 3, 4'b0001};
        tbl[7]  = '{10'b00_11_10_1011, 3, 4'b1000};
        tbl[8]  = '{10'b10_11_101010, 3, 4'b1000};   // addi R3,42
        tbl[9]  = '{10'b11_00_000111, 3, 4'b0001};   // subi R0,7
        tbl[10] = '{10'b01_00_000000, 1, 4'b0000};   // illegal class
        tbl[11] = '{10'b00_00_00_1111, 1, 4'b0000};  // illegal op
        tbl[12] = '{10'b00_11_11_1100, 1, 4'b0000};  // illegal op

        cur  = '0;
        ir_m = '0;
        @(posedge CLKb);

        // reset state
        tick(1'b1, 1'b0, 10'd0);
        tick(1'b1, 1'b0, 10'd0);
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_imm", 32'(IMM), 32'd0);

        // ld R2: one-cycle instruction, then back to IDLE with everything low
        tick(1'b0, 1'b1, 10'b00_10_00_0000);
        chk("ld_enw", 32'(ENW), 32'd1);
        chk("ld_rin", 32'(Rin), 32'b0100);
        chk("ld_done", 32'(Done), 32'd1);
        tick(1'b0, 1'b0, 10'd0);
        chk("ld_idle_busy", 32'(Busy), 32'd0);
        chk("ld_idle_rin", 32'(Rin), 32'd0);

        // add R1,R3 step by step
        tick(1'b0, 1'b1, 10'b00_01_11_0010);
        chk("add_t1_rout", 32'(Rout), 32'b0010);
        chk("add_t1_ain", 32'(Ain), 32'd1);
        tick(1'b0, 1'b0, 10'd0);
        chk("add_t2_rout", 32'(Rout), 32'b1000);
        chk("add_t2_fn", 32'(FN), 32'b0010);
        chk("add_t2_gin", 32'(Gin), 32'd1);
        tick(1'b0, 1'b0, 10'd0);
        chk("add_t3_gout", 32'(Gout), 32'd1);
        chk("add_t3_rin", 32'(Rin), 32'b0010);
        chk("add_t3_done", 32'(Done), 32'd1);
        tick(1'b0, 1'b0, 10'd0);

        // addi R3,42
        tick(1'b0, 1'b1, 10'b10_11_101010);
        tick(1'b0, 1'b0, 10'd0);
        chk("addi_t2_extimm", 32'(ExtImm), 32'd1);
        chk("addi_t2_imm", 32'(IMM), 32'h02A);
        chk("addi_t2_fn", 32'(FN), 32'b0010);
        tick(1'b0, 1'b0, 10'd0);
        chk("addi_t3_rin", 32'(Rin), 32'b1000);
        chk("addi_t3_done", 32'(Done), 32'd1);
        tick(1'b0, 1'b0, 10'd0);

        // table: latency to Done and destination strobe at Done
        for (int k = 0; k < 13; k++) begin
            int n;
            tick(1'b0, 1'b1, tbl[k].inst);
            n = 1;
            while (!Done && n < 6) begin
                tick(1'b0, 1'b0, 10'd0);
                n++;
            end
            chk($sformatf("tbl%0d_lat", k), 32'(n), 32'(tbl[k].lat));
            chk($sformatf("tbl%0d_rin", k), 32'(Rin), 32'(tbl[k].rin_done));
            tick(1'b0, 1'b0, 10'd0);
            chk($sformatf("tbl%0d_idle", k), 32'(Busy), 32'd0);
        end

        // Exec held high: sub, then a new instruction accepted after one IDLE cycle
        tick(1'b0, 1'b1, 10'b00_01_10_0011);
        tick(1'b0, 1'b1, 10'b00_01_10_0011);
        tick(1'b0, 1'b1, 10'b00_01_10_0011);
        chk("hold_t3_done", 32'(Done), 32'd1);
        tick(1'b0, 1'b1, 10'b00_11_00_0000);
        chk("hold_gap_busy", 32'(Busy), 32'd0);
        tick(1'b0, 1'b1, 10'b00_11_00_0000);
        chk("hold_second_enw", 32'(ENW), 32'd1);
        chk("hold_second_rin", 32'(Rin), 32'b1000);
        tick(1'b0, 1'b0, 10'd0);

        // reset during T2 of xor aborts without Done or Rin
        tick(1'b0, 1'b1, 10'b00_10_01_0111);
        tick(1'b0, 1'b0, 10'd0);
        chk("xor_t2_busy", 32'(Busy), 32'd1);
        tick(1'b1, 1'b0, 10'd0);
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_rin", 32'(Rin), 32'd0);
        chk("abort_busy", 32'(Busy), 32'd0);
        tick(1'b0, 1'b0, 10'd0);
        chk("abort_after_done", 32'(Done), 32'd0);
        chk("abort_after_rin", 32'(Rin), 32'd0);

        // reset wins over a simultaneous Exec
        tick(1'b1, 1'b1, 10'b00_10_00_0000);
        chk("rst_vs_exec_busy", 32'(Busy), 32'd0);
        tick(1'b0, 1'b0, 10'd0);

        // illegal encodings: Done only
        tick(1'b0, 1'b1, 10'b01_00_000000);
        chk("ill1_strobes", 32'({Rin, Rout, Gin, Ain}), 32'd0);
        chk("ill1_done", 32'(Done), 32'd1);
        tick(1'b0, 1'b0, 10'd0);
        tick(1'b0, 1'b1, 10'b00_00_00_1111);
        chk("ill2_strobes", 32'({Rin, Rout, Gin, Ain}), 32'd0);
        chk("ill2_done", 32'(Done), 32'd1);
        tick(1'b0, 1'b0, 10'd0);
        chk("ill2_idle", 32'(Busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
